// File: rtl/decoder_n_to_m_stream.sv
// Registered N-to-M select decoder: one-hot, thermometer, active-low one-hot or one-hot scan.
// Latency: first output beat 1 cycle after a select is accepted; scans emit one beat per consume.
// Backpressure: beats hold while out_ready=0; de_ready only rises once the final beat can leave.
module decoder_n_to_m_stream #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    output logic             de_ready,
    input  logic [SEL_W-1:0] de_in,
    input  logic [1:0]       de_mode,
    output logic [OUT_W-1:0] de_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             de_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // One bit wider than the select so OUT_W == 2**SEL_W is representable.
    localparam logic [SEL_W:0] OUT_LIM = (SEL_W+1)'(OUT_W);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   scan_idx, idx_d;
    logic [SEL_W-1:0]   scan_k, k_d;
    logic               in_range;
    logic               accept;
    logic               consume;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i == int'(k)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] thermo(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (i <= int'(k));
        end
        return v;
    endfunction

    assign out_valid = (state_q != IDLE);
    assign de_ready  = !out_valid | (out_ready & last_q);
    assign accept    = de_valid & de_ready;
    assign consume   = out_valid & out_ready;
    assign in_range  = ({1'b0, de_in} < OUT_LIM);

    assign de_out    = out_q;
    assign out_last  = last_q;
    assign de_err    = err_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        last_d  = last_q;
        err_d   = err_q;
        idx_d   = scan_idx;
        k_d     = scan_k;

        if (accept) begin
            // Acceptance only happens when idle or while the final beat leaves,
            // so this branch also covers the back-to-back handover.
            state_d = HOLD;
            idx_d   = '0;
            k_d     = de_in;
            last_d  = 1'b1;
            err_d   = 1'b0;
            if (!in_range) begin
                out_d = '0;
                err_d = 1'b1;
            end else begin
                case (de_mode)
                    2'b00:   out_d = onehot(de_in);
                    2'b01:   out_d = thermo(de_in);
                    2'b11:   out_d = ~onehot(de_in);
                    default: begin
                        out_d = onehot('0);
                        if (de_in != '0) begin
                            last_d  = 1'b0;
                            state_d = SCAN;
                        end
                    end
                endcase
            end
        end else if (consume) begin
            if (state_q == SCAN && !last_q) begin
                idx_d  = scan_idx + SEL_W'(1);
                out_d  = onehot(idx_d);
                last_d = (idx_d == scan_k);
            end else begin
                state_d = IDLE;
                out_d   = '0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            scan_idx <= '0;
            scan_k   <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            last_q   <= last_d;
            err_q    <= err_d;
            scan_idx <= idx_d;
            scan_k   <= k_d;
        end
    end

endmodule

// File: tb/tb_decoder_n_to_m_stream.sv
// Bench for decoder_n_to_m_stream: a full-range instance (OUT_W=8) and a truncated one (OUT_W=6),
// table vectors, directed multi-cycle sequences, and random traffic against a beat-queue model.
module tb_decoder_n_to_m_stream;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    typedef struct {
        int         u;
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] exp_out;
        logic       exp_err;
        int         beats;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv    [2];
    logic       ory   [2];
    logic [2:0] din   [2];
    logic [1:0] dmode [2];
    logic       ov    [2];
    logic       drdy  [2];
    logic       olast [2];
    logic       oerr  [2];
    logic [7:0] out0;
    logic [5:0] out1;

    int checks   = 0;
    int failures = 0;

    beat_t q0[$];
    beat_t q1[$];
    logic  stall [2];
    beat_t held  [2];
    row_t  vec   [15];

    always #5 clk = ~clk;

    decoder_n_to_m_stream #(.SEL_W(3), .OUT_W(8)) dut0 (
        .clk(clk), .rst(rst), .de_valid(dv[0]), .de_ready(drdy[0]), .de_in(din[0]),
        .de_mode(dmode[0]), .de_out(out0), .out_valid(ov[0]), .out_ready(ory[0]),
        .out_last(olast[0]), .de_err(oerr[0])
    );

    decoder_n_to_m_stream #(.SEL_W(3), .OUT_W(6)) dut1 (
        .clk(clk), .rst(rst), .de_valid(dv[1]), .de_ready(drdy[1]), .de_in(din[1]),
        .de_mode(dmode[1]), .de_out(out1), .out_valid(ov[1]), .out_ready(ory[1]),
        .out_last(olast[1]), .de_err(oerr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dout(input int u);
        return (u == 0) ? out0 : {2'b00, out1};
    endfunction

    function automatic void qpush(input int u, input beat_t b);
        if (u == 0) q0.push_back(b); else q1.push_back(b);
    endfunction

    function automatic beat_t qpop(input int u);
        return (u == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    // Expected beat sequence for one accepted select, straight from the code definitions.
    function automatic void model_push(input int u, input int k, input int m);
        int ow;
        ow = (u == 0) ? 8 : 6;
        if (k >= ow) begin
            qpush(u, beat_t'{8'h00, 1'b1, 1'b1});
        end else begin
            case (m)
                0: qpush(u, beat_t'{8'(1 << k), 1'b1, 1'b0});
                1: qpush(u, beat_t'{8'((1 << (k + 1)) - 1), 1'b1, 1'b0});
                3: qpush(u, beat_t'{8'(~(1 << k) & ((1 << ow) - 1)), 1'b1, 1'b0});
                default: for (int j = 0; j <= k; j++) qpush(u, beat_t'{8'(1 << j), j == k, 1'b0});
            endcase
        end
    endfunction

    task automatic mon(input int u);
        beat_t cur;
        beat_t exp;
        cur = beat_t'{dout(u), olast[u], oerr[u]};
        if (rst) begin
            if (u == 0) q0.delete(); else q1.delete();
            stall[u] = 1'b0;
            return;
        end
        chk($sformatf("de_ready%0d", u), drdy[u], !ov[u] | (ory[u] & olast[u]));
        if (stall[u]) chk($sformatf("hold%0d", u), {ov[u], cur}, {1'b1, held[u]});
        if (ov[u] && ory[u]) begin
            if (qsize(u) == 0) begin
                chk($sformatf("beat_expected%0d", u), qsize(u), 1);
            end else begin
                exp = qpop(u);
                chk($sformatf("beat%0d", u), cur, exp);
            end
        end
        if (dv[u] && drdy[u]) model_push(u, int'(din[u]), int'(dmode[u]));
        stall[u] = ov[u] & !ory[u];
        held[u]  = cur;
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon(u);
    end

    task automatic send(input int u, input logic [2:0] sel, input logic [1:0] mode);
        logic acc;
        acc = 1'b0;
        dv[u] = 1'b1; din[u] = sel; dmode[u] = mode;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = drdy[u];
        end
        chk("accept", acc, 1'b1);
        @(posedge clk); #1;
        dv[u] = 1'b0;
    endtask

    task automatic collect(input int u, input logic [7:0] exp_out, input logic exp_err, input int beats);
        int  n;
        logic done;
        n = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ov[u] && ory[u]) begin
                n++;
                if (olast[u]) begin
                    done = 1'b1;
                    chk("row_out", dout(u), exp_out);
                    chk("row_err", oerr[u], exp_err);
                    chk("row_beats", n, beats);
                end
            end
        end
        chk("row_done", done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int j;
        logic tog;
        for (int u = 0; u < 2; u++) begin
            dv[u] = 1'b1; ory[u] = 1'b1; din[u] = 3'd0; dmode[u] = 2'b00;
            stall[u] = 1'b0; held[u] = '0;
        end

        // Reset held two cycles with de_valid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ov[0], 1'b0);
        chk("rst_out", out0, 8'h00);
        chk("rst_ready", drdy[0], 1'b1);
        chk("rst_last_err", {olast[0], oerr[0]}, 2'b00);
        @(posedge clk); #1;
        dv[0] = 1'b0; dv[1] = 1'b0; rst = 1'b0;

        vec[0]  = '{0, 3'd0, 2'b00, 8'h01, 1'b0, 1};
        vec[1]  = '{0, 3'd7, 2'b00, 8'h80, 1'b0, 1};
        vec[2]  = '{0, 3'd5, 2'b01, 8'h3F, 1'b0, 1};
        vec[3]  = '{0, 3'd2, 2'b11, 8'hFB, 1'b0, 1};
        vec[4]  = '{0, 3'd3, 2'b10, 8'h08, 1'b0, 4};
        vec[5]  = '{0, 3'd0, 2'b10, 8'h01, 1'b0, 1};
        vec[6]  = '{0, 3'd7, 2'b01, 8'hFF, 1'b0, 1};
        vec[7]  = '{0, 3'd0, 2'b11, 8'hFE, 1'b0, 1};
        vec[8]  = '{1, 3'd6, 2'b00, 8'h00, 1'b1, 1};
        vec[9]  = '{1, 3'd7, 2'b01, 8'h00, 1'b1, 1};
        vec[10] = '{1, 3'd6, 2'b10, 8'h00, 1'b1, 1};
        vec[11] = '{1, 3'd7, 2'b11, 8'h00, 1'b1, 1};
        vec[12] = '{1, 3'd5, 2'b10, 8'h20, 1'b0, 6};
        vec[13] = '{1, 3'd5, 2'b11, 8'h1F, 1'b0, 1};
        vec[14] = '{1, 3'd5, 2'b01, 8'h3F, 1'b0, 1};
        for (int i = 0; i < 15; i++) begin
            send(vec[i].u, vec[i].sel, vec[i].mode);
            collect(vec[i].u, vec[i].exp_out, vec[i].exp_err, vec[i].beats);
        end

        // Back-to-back one-hot sweep: one beat per cycle, no bubble
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            dv[0] = (i < 8); din[0] = 3'(i); dmode[0] = 2'b00;
            @(negedge clk);
            if (i < 8) chk("sweep_ready", drdy[0], 1'b1);
            if (i > 0) chk("sweep_out", {ov[0], out0}, {1'b1, 8'(1 << (i - 1))});
        end
        @(posedge clk); #1;
        dv[0] = 1'b0;

        // Scan of 3 with out_ready toggling
        send(0, 3'd3, 2'b10);
        j = 0; tog = 1'b1;
        for (int c = 0; c < 20 && j < 4; c++) begin
            ory[0] = tog;
            @(negedge clk);
            chk("scan_vld", ov[0], 1'b1);
            chk("scan_out", out0, 8'(1 << j));
            chk("scan_last", olast[0], j == 3);
            chk("scan_rdy", drdy[0], tog && j == 3);
            if (tog) j++;
            tog = !tog;
            @(posedge clk); #1;
        end
        chk("scan_beats", j, 4);
        ory[0] = 1'b1;
        @(posedge clk); #1;

        // Reset on the third beat of a scan of 7
        send(0, 3'd7, 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midscan_beat3", out0, 8'h04);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midscan_flush", ov[0], 1'b0);
        @(posedge clk); #1;
        send(0, 3'd4, 2'b00);
        collect(0, 8'h10, 1'b0, 1);

        // Random traffic on both instances, checked by the monitor's queue model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                dv[u]    = ($urandom_range(99) < 50);
                din[u]   = 3'($urandom_range(7));
                dmode[u] = 2'($urandom_range(3));
                ory[u]   = ($urandom_range(99) < 70);
            end
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin dv[u] = 1'b0; ory[u] = 1'b1; end
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_vld", {ov[0], ov[1]}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
